gps_dump_fifo: RTL
==================

Name: gps_dump_fifo

Overview:
Downstream capture stage for gps_ca_correlator_channel, in the sample-clock domain. On each correlator dump pulse it snapshots the six early/prompt/late I/Q accumulators into a small FIFO, tagged with a free-running dump sequence number. Software polling through gp2021_axi_wrapper is slow and jittery; the FIFO lets that read path fall behind by up to DEPTH integrations without losing data. Dropped dumps are counted and stay visible.

Parameters:
ACC_W, 18, accumulator width (signed), matches correlator ACC_W
DEPTH, 8, FIFO entries; power of two, 2..64
SEQ_W, 32, dump sequence counter width

Ports:
samp_clk  in  1  sample clock; the only clock
samp_rst  in  1  reset, synchronous, active-high
clear  in  1  synchronous flush: empties FIFO, zeroes overflow state; seq unaffected
dump_pulse  in  1  one-cycle strobe from correlator; accumulators valid this cycle
i_early, q_early, i_prompt, q_prompt, i_late, q_late  in  ACC_W each  signed accumulator values
rd_valid  out  1  head entry available
rd_ready  in  1  consumer accepts head when rd_valid & rd_ready
rd_seq  out  SEQ_W  sequence number of head entry
rd_ie, rd_qe, rd_ip, rd_qp, rd_il, rd_ql  out  ACC_W each  head entry accumulators
level  out  clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: at least one dump dropped since reset/clear
drop_cnt  out  16  dropped-dump count, saturates at 0xFFFF
dump_seq  out  SEQ_W  total dumps seen (accepted + dropped)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (samp_rst=1 at an edge): rd_valid=0, level=0, overflow=0, drop_cnt=0, dump_seq=0. rd_* data=0. Reset wins over every other input.
- Sequence tagging: every dump_pulse increments dump_seq, wrapping modulo 2^SEQ_W.
  - An entry stores the pre-increment value, so the first dump after reset has rd_seq=0.
  - Dropped dumps still consume a seq value; gaps in rd_seq identify the losses.
- Push: dump_pulse & (level<DEPTH), or dump_pulse & full & pop in the same cycle.
  - The six inputs are captured exactly as presented in the dump_pulse cycle.
- Drop: dump_pulse & full & no pop in that cycle.
  - Entry is discarded, overflow<=1, drop_cnt increments and saturates at 0xFFFF.
- Pop: rd_valid & rd_ready. Head advances and level decrements.
- Simultaneous push and pop: level is unchanged.
  - When level=1, the new entry becomes head on the following cycle.
- Show-ahead (FWFT) output:
  - rd_* fields are registered and always show the head.
  - rd_valid = (level!=0), registered.
  - A push into an empty FIFO at edge N gives rd_valid=1 with the data after edge N (1-cycle latency).
  - rd_* fields are stable while rd_valid & !rd_ready.
- Pop on empty (rd_ready with rd_valid=0): ignored.
- Pointers: log2(DEPTH) bits, wrapping naturally. level is tracked explicitly, so full and empty are unambiguous.
- clear: same cycle effect as reset, except dump_seq continues.
  - clear together with dump_pulse: the flush happens and the dump is not stored, but dump_seq still increments.
- dump_pulse held high for several cycles: each cycle is treated as a separate dump. The correlator guarantees single-cycle pulses.
- Storage: a DEPTH x (SEQ_W+6*ACC_W) register array or inferred distributed RAM. There is no read-during-write hazard, because the head register is loaded from the array or bypassed from the input when pushing into an empty FIFO or into level=1 with a pop.

Decomposition:
- Package gps_dump_pkg:
  - dump_entry_t packed struct {seq, ie, qe, ip, qp, il, ql}, parameterised by package constants GPS_ACC_W=18 and GPS_SEQ_W=32.
  - DROP_CNT_W=16.
- Sub-module gps_sync_fifo_fwft: a generic single-clock show-ahead FIFO of WIDTH x DEPTH with push, pop, full, empty and level.
- gps_dump_fifo adds sequence tagging, drop accounting and struct packing/unpacking around it.

Test Plan:
1. Reset, then 3 dump_pulses with ip=100,200,300 and rd_ready=0 -> level=3, rd_valid=1, rd_seq=0, rd_ip=100; popping 3 gives seq 0,1,2 and ip 100,200,300, then rd_valid=0.
2. DEPTH=8, rd_ready=0, 10 pulses -> level=8, overflow=1, drop_cnt=2, dump_seq=10; draining yields seq 0..7.
3. Full FIFO, dump_pulse and pop in the same cycle -> level stays 8, drop_cnt unchanged, tail entry seq matches the new dump.
4. Empty FIFO, rd_ready=1 held, single pulse ie=-131072 (min ACC_W) -> rd_valid=1 exactly one cycle after the pulse, rd_ie=-131072, rd_valid=0 the next cycle.
5. Level 5, overflow=1, assert clear together with dump_pulse -> level=0, overflow=0, drop_cnt=0, dump_seq advanced by 1; next dump has rd_seq equal to the prior dump_seq+1.
6. 70000 pulses with drain disabled (DEPTH=8) -> drop_cnt saturates at 65535; samp_rst mid-run gives all outputs 0 the next cycle.

Source files
------------

// File: rtl/gps_dump_pkg.sv
// Shared types and constants for the GPS correlator dump capture path.
//   GPS_ACC_W    : accumulator width (signed), matches the correlator
//   GPS_SEQ_W    : dump sequence counter width
//   DROP_CNT_W   : width of the saturating dropped-dump counter
//   dump_entry_t : one captured dump {seq, ie, qe, ip, qp, il, ql}, seq in the MSBs
//   sat_inc_drop : saturating increment for the drop counter
package gps_dump_pkg;

  localparam int GPS_ACC_W  = 18;
  localparam int GPS_SEQ_W  = 32;
  localparam int DROP_CNT_W = 16;

  typedef struct packed {
    logic        [GPS_SEQ_W-1:0] seq;
    logic signed [GPS_ACC_W-1:0] ie;
    logic signed [GPS_ACC_W-1:0] qe;
    logic signed [GPS_ACC_W-1:0] ip;
    logic signed [GPS_ACC_W-1:0] qp;
    logic signed [GPS_ACC_W-1:0] il;
    logic signed [GPS_ACC_W-1:0] ql;
  } dump_entry_t;

  localparam int DUMP_ENTRY_W = $bits(dump_entry_t);

  function automatic logic [DROP_CNT_W-1:0] sat_inc_drop(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/gps_dump_fifo_if.sv
// Bus bundle between the correlator/consumer side and gps_dump_fifo.
//   master : drives clear, dump_pulse, the six accumulators and rd_ready;
//            observes the head entry, level and drop accounting.
//   slave  : the dump FIFO itself (mirror image of master).
interface gps_dump_fifo_if
  import gps_dump_pkg::*;
#(
  parameter int ACC_W = GPS_ACC_W,
  parameter int DEPTH = 8,
  parameter int SEQ_W = GPS_SEQ_W
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                    clear;
  logic                    dump_pulse;
  logic signed [ACC_W-1:0] i_early;
  logic signed [ACC_W-1:0] q_early;
  logic signed [ACC_W-1:0] i_prompt;
  logic signed [ACC_W-1:0] q_prompt;
  logic signed [ACC_W-1:0] i_late;
  logic signed [ACC_W-1:0] q_late;

  logic                    rd_valid;
  logic                    rd_ready;
  logic [SEQ_W-1:0]        rd_seq;
  logic signed [ACC_W-1:0] rd_ie;
  logic signed [ACC_W-1:0] rd_qe;
  logic signed [ACC_W-1:0] rd_ip;
  logic signed [ACC_W-1:0] rd_qp;
  logic signed [ACC_W-1:0] rd_il;
  logic signed [ACC_W-1:0] rd_ql;

  logic [LVL_W-1:0]        level;
  logic                    overflow;
  logic [DROP_CNT_W-1:0]   drop_cnt;
  logic [SEQ_W-1:0]        dump_seq;

  modport master (
    output clear, dump_pulse, i_early, q_early, i_prompt, q_prompt, i_late, q_late, rd_ready,
    input  rd_valid, rd_seq, rd_ie, rd_qe, rd_ip, rd_qp, rd_il, rd_ql,
    input  level, overflow, drop_cnt, dump_seq
  );

  modport slave (
    input  clear, dump_pulse, i_early, q_early, i_prompt, q_prompt, i_late, q_late, rd_ready,
    output rd_valid, rd_seq, rd_ie, rd_qe, rd_ip, rd_qp, rd_il, rd_ql,
    output level, overflow, drop_cnt, dump_seq
  );

endinterface

// File: rtl/gps_sync_fifo_fwft.sv
// Generic single-clock show-ahead (FWFT) FIFO.
//   clk, srst : clock, synchronous active-high reset
//   flush     : synchronous empty, same effect as reset
//   push      : write wr_data; accepted when not full, or when full and popping
//   pop       : consume head; ignored when empty
//   rd_data   : registered head entry, rd_valid registered (level != 0)
//   full, empty, level : occupancy status (level tracked explicitly)
module gps_sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [LVL_W-1:0] level_reg;
  logic [LVL_W-1:0] level_next;
  logic [WIDTH-1:0] head_reg;
  logic             valid_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full       = (level_reg == LVL_W'(DEPTH));
  assign empty      = (level_reg == '0);
  assign pop_ok     = pop & valid_reg;
  assign push_ok    = push & (~full | pop_ok);
  assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);

  always_comb begin
    level_next = level_reg;
    case ({push_ok, pop_ok})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  // Storage carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push_ok && !srst && !flush) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      head_reg   <= '0;
      valid_reg  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_inc;
      level_reg <= level_next;
      valid_reg <= (level_next != '0);
      // The head register always mirrors mem[rd_ptr]. The slot after the head
      // is not yet written when level is 1, so the incoming word is bypassed
      // there and into an empty FIFO. When full, the write lands on the slot
      // being popped, never on rd_ptr+1, so the array read stays valid.
      if (pop_ok) begin
        if (level_reg == LVL_W'(1)) begin
          if (push_ok) head_reg <= wr_data;
        end else begin
          head_reg <= mem[rd_ptr_inc];
        end
      end else if (push_ok && empty) begin
        head_reg <= wr_data;
      end
    end
  end

  assign rd_data  = head_reg;
  assign rd_valid = valid_reg;
  assign level    = level_reg;

endmodule

// File: rtl/gps_dump_fifo.sv
// Capture FIFO for correlator dumps, sample-clock domain.
//   samp_clk, samp_rst : clock, synchronous active-high reset
//   bus (slave)        : dump inputs, FWFT read port, level/overflow/drop_cnt/dump_seq
// Each dump_pulse takes a sequence number (pre-increment value). Dumps that
// arrive while the FIFO is full with no pop in the same cycle are dropped,
// still consuming a sequence number, and are counted in a saturating counter.
module gps_dump_fifo
  import gps_dump_pkg::*;
#(
  parameter int ACC_W = GPS_ACC_W,
  parameter int DEPTH = 8,
  parameter int SEQ_W = GPS_SEQ_W
) (
  input  logic          samp_clk,
  input  logic          samp_rst,
  gps_dump_fifo_if.slave bus
);
  localparam int ENTRY_W = SEQ_W + 6 * ACC_W;
  localparam int LVL_W   = $clog2(DEPTH) + 1;

  logic [ENTRY_W-1:0]      wr_entry;
  logic [ENTRY_W-1:0]      head_entry;
  logic signed [ACC_W-1:0] acc_in  [6];
  logic signed [ACC_W-1:0] acc_out [6];
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_valid;
  logic [LVL_W-1:0]        fifo_level;
  logic                    pop;
  logic                    push;
  logic                    drop;

  logic [SEQ_W-1:0]        dump_seq_reg;
  logic                    overflow_reg;
  logic [DROP_CNT_W-1:0]   drop_cnt_reg;

  assign acc_in[0] = bus.i_early;
  assign acc_in[1] = bus.q_early;
  assign acc_in[2] = bus.i_prompt;
  assign acc_in[3] = bus.q_prompt;
  assign acc_in[4] = bus.i_late;
  assign acc_in[5] = bus.q_late;

  // Entry layout matches dump_entry_t: seq in the MSBs, then ie..ql downwards.
  assign wr_entry[ENTRY_W-1 -: SEQ_W] = dump_seq_reg;
  assign bus.rd_seq = head_entry[ENTRY_W-1 -: SEQ_W];

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_fields
      assign wr_entry[(5 - gi) * ACC_W +: ACC_W] = acc_in[gi];
      assign acc_out[gi] = head_entry[(5 - gi) * ACC_W +: ACC_W];
    end
  endgenerate

  assign bus.rd_ie = acc_out[0];
  assign bus.rd_qe = acc_out[1];
  assign bus.rd_ip = acc_out[2];
  assign bus.rd_qp = acc_out[3];
  assign bus.rd_il = acc_out[4];
  assign bus.rd_ql = acc_out[5];

  // A dump that coincides with clear is flushed along with the contents.
  assign pop  = ~fifo_empty & bus.rd_ready;
  assign push = bus.dump_pulse & ~bus.clear;
  assign drop = bus.dump_pulse & ~bus.clear & fifo_full & ~pop;

  gps_sync_fifo_fwft #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (samp_clk),
    .srst     (samp_rst),
    .flush    (bus.clear),
    .push     (push),
    .wr_data  (wr_entry),
    .pop      (pop),
    .rd_data  (head_entry),
    .rd_valid (fifo_valid),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  always_ff @(posedge samp_clk) begin
    if (samp_rst) begin
      dump_seq_reg <= '0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      // Sequence keeps counting through clear so software sees the gap.
      if (bus.dump_pulse) dump_seq_reg <= dump_seq_reg + SEQ_W'(1);
      if (bus.clear) begin
        overflow_reg <= 1'b0;
        drop_cnt_reg <= '0;
      end else if (drop) begin
        overflow_reg <= 1'b1;
        drop_cnt_reg <= sat_inc_drop(drop_cnt_reg);
      end
    end
  end

  assign bus.rd_valid = fifo_valid;
  assign bus.level    = fifo_level;
  assign bus.overflow = overflow_reg;
  assign bus.drop_cnt = drop_cnt_reg;
  assign bus.dump_seq = dump_seq_reg;

endmodule
